matmul_arbiter: RTL and testbench
=================================

Name: matmul_arbiter

Overview:
- Shares one matrix_mul instance between N_REQ requesters, e.g. camera transform, ray-direction normalize and inverse-direction setup.
- Round-robin arbitration; each winner gets exactly one operation.
- Holds the winner's operands and mode bits stable on the matrix_mul inputs from issue until rdy.
- Returns the 4-word result tagged with the requester index.
- Sits between the raycaster front-end stages and matrix_mul.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- IDW, 2, width of the result-tag index; must satisfy 2**IDW >= N_REQ.
- DRAIN, 16, cycles after reset before the first issue. matrix_mul has no reset, so its internal pipeline must drain first.
- TIMEOUT, 255, maximum WAIT cycles; used only when the optional feature is enabled.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  request per requester; held until gnt
- req_op  in  2*N_REQ  per-requester op: 00 transform, 01 transform+normalize, 10 t_mode, 11 invert v0..v2
- req_vec  in  128*N_REQ  per-requester {v3,v2,v1,v0}, signed 16.16
- gnt  out  N_REQ  one-hot, 1-cycle pulse when a request is accepted
- done  out  1  1-cycle pulse when res is valid
- res  out  128  {u3,u2,u1,u0}, held until the next done
- res_id  out  IDW  index of the requester that owns res
- err  out  1  timeout flag; qualifies done
- busy  out  1  high in any state except IDLE
- mm_nd, mm_invert_v_nd  out  1  start pulses to matrix_mul
- mm_normalize, mm_t_mode  out  1  mode bits to matrix_mul
- mm_v  out  128  operand vector to matrix_mul
- mm_u  in  128  matrix_mul result
- mm_rdy  in  1  matrix_mul ready pulse

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: all outputs 0; state DRAIN; round-robin pointer 0; latched operands 0.
- Reset mid-operation: abandon the operation with no done, re-enter DRAIN, discard any later mm_rdy.

States:
- DRAIN: count DRAIN cycles, ignore req and mm_rdy, then go to IDLE.
- IDLE:
  - Pick the first asserted req at or after the pointer, wrapping modulo N_REQ.
  - Latch its index, op and vector.
  - Pulse gnt[winner] and go to ISSUE.
  - Set pointer = winner+1, wrapping modulo N_REQ.
  - No req: stay in IDLE.
- ISSUE:
  - Op 11: mm_invert_v_nd=1 for one cycle.
  - Any other op: mm_nd=1 for one cycle.
  - Then go to WAIT.
- WAIT: on mm_rdy, register mm_u into res, set res_id, pulse done the next cycle (DONE), then return to IDLE.

Latched operands and mode bits:
- mm_v, mm_normalize (op==01) and mm_t_mode (op==10) are driven from the latched registers.
- They stay constant from ISSUE through the mm_rdy cycle, because matrix_mul samples v0..v3 over successive cycles.
- In IDLE and DRAIN they are driven to 0.

Timing and throughput:
- Request-to-issue latency: req seen in IDLE at cycle t gives gnt at t+1 and mm_nd at t+2.
- Minimum turnaround is mm_rdy + 1 cycle; there is one IDLE cycle between jobs.

Handshake rules:
- A requester may drop req before gnt, which withdraws it.
- A requester must drop req in the cycle after gnt. A req still high then is treated as a new request.
- mm_rdy outside WAIT is ignored.
- At most one job is in flight; there is no queue.

Optional Feature:
- Macro MATMUL_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WAIT.
  - If TIMEOUT cycles pass without mm_rdy, pulse done with err=1 and res unchanged, then go to DRAIN.
  - err is otherwise 0.
- Undefined: no counter, WAIT waits indefinitely, err is tied 0.

Test Plan:
- Reset, then req[0]=1 at cycle 5: gnt[0] not before cycle DRAIN+1; mm_nd a single pulse; mm_v == req_vec[0] held stable until mm_rdy; done one cycle after mm_rdy with res==mm_u and res_id==0.
- req=111 held continuously: grants go 0,1,2,0,… with exactly one gnt per job and never two outstanding.
- op=11 on requester 2: mm_invert_v_nd pulses, mm_nd stays 0; op=10: mm_t_mode=1 from ISSUE to rdy; op=01: mm_normalize=1.
- Spurious mm_rdy in IDLE: no done and res unchanged; rst asserted in WAIT: no done, and a later mm_rdy is ignored.
- MATMUL_ARB_TIMEOUT_EN, TIMEOUT=20, mm_rdy withheld: done with err=1 twenty cycles after ISSUE, then DRAIN; without the macro, busy stays 1.

Source files
------------

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one matrix_mul between N_REQ requesters; one job in flight at a time.
// Optional WAIT timeout enabled by defining MATMUL_ARB_TIMEOUT_EN.
module matmul_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned IDW     = 2,
  parameter int unsigned DRAIN   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [2*N_REQ-1:0]     req_op_i,
  input  logic [128*N_REQ-1:0]   req_vec_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   done_o,
  output logic [127:0]           res_o,
  output logic [IDW-1:0]         res_id_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   mm_nd_o,
  output logic                   mm_invert_v_nd_o,
  output logic                   mm_normalize_o,
  output logic                   mm_t_mode_o,
  output logic [127:0]           mm_v_o,
  input  logic [127:0]           mm_u_i,
  input  logic                   mm_rdy_i
);

  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {StDrain, StIdle, StIssue, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [127:0]     vec_q, vec_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             nd_q, nd_d;
  logic             inv_q, inv_d;
  logic             done_q, done_d;
  logic [127:0]     res_q, res_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             busy_q;
  logic             err_d;

  logic             found;
  int unsigned      win;
  int unsigned      cand;

  // First asserted request at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = 0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && |(req_i & (N_REQ'(1) << cand))) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef MATMUL_ARB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q;
  logic       tmo_hit;

  assign tmo_d   = (state_q == StWait) ? tmo_q + 8'd1 : 8'd0;
  assign tmo_hit = (state_q == StWait) && !mm_rdy_i && (tmo_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    op_d     = op_q;
    vec_d    = vec_q;
    gnt_d    = '0;
    nd_d     = 1'b0;
    inv_d    = 1'b0;
    done_d   = 1'b0;
    res_d    = res_q;
    res_id_d = res_id_q;
    err_d    = 1'b0;
    unique case (state_q)
      StDrain: begin
        if (drain_q == DW'(DRAIN - 1)) begin
          drain_d = '0;
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StIdle: begin
        if (found) begin
          idx_d   = IDW'(win);
          op_d    = 2'(req_op_i >> (2 * win));
          vec_d   = 128'(req_vec_i >> (128 * win));
          gnt_d   = N_REQ'(1) << win;
          ptr_d   = IDW'((win + 1 == N_REQ) ? 32'd0 : win + 1);
          state_d = StIssue;
        end
      end
      StIssue: begin
        nd_d    = (op_q != 2'b11);
        inv_d   = (op_q == 2'b11);
        state_d = StWait;
      end
      StWait: begin
        if (mm_rdy_i) begin
          res_d    = mm_u_i;
          res_id_d = idx_q;
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (tmo_hit) begin
          // Result is left untouched; matrix_mul is presumed wedged, so drain it again.
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StDrain;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StDrain;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StDrain;
      drain_q  <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      op_q     <= '0;
      vec_q    <= '0;
      gnt_q    <= '0;
      nd_q     <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      vec_q    <= vec_d;
      gnt_q    <= gnt_d;
      nd_q     <= nd_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  // Operands are only presented while a job owns matrix_mul.
  logic active;
  assign active = (state_q == StIssue) || (state_q == StWait);

  assign gnt_o            = gnt_q;
  assign done_o           = done_q;
  assign res_o            = res_q;
  assign res_id_o         = res_id_q;
  assign busy_o           = busy_q;
  assign mm_nd_o          = nd_q;
  assign mm_invert_v_nd_o = inv_q;
  assign mm_v_o           = active ? vec_q : '0;
  assign mm_normalize_o   = active && (op_q == 2'b01);
  assign mm_t_mode_o      = active && (op_q == 2'b10);

endmodule

// File: tb/tb_matmul_arbiter.sv
// Self-checking bench for matmul_arbiter: randomized jobs against a round-robin reference model.
// Timeout scenario checked with or without MATMUL_ARB_TIMEOUT_EN.
module tb_matmul_arbiter;
  localparam int N = 3;
  localparam int IDW = 2;
  localparam int DRAIN = 16;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] req_op;
  logic [128*N-1:0] req_vec;
  logic [N-1:0] gnt;
  logic done, err, busy, mm_nd, mm_inv, mm_norm, mm_tm, mm_rdy = 1'b0;
  logic [127:0] res, mm_v, mm_u = '0;
  logic [IDW-1:0] res_id;

  logic [1:0] ops[N];
  logic [127:0] vecs[N];

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  logic [127:0] last_res = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]    = ops[i];
      req_vec[128*i +: 128] = vecs[i];
    end
  end

  matmul_arbiter #(.N_REQ(N), .IDW(IDW), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_op_i(req_op), .req_vec_i(req_vec),
    .gnt_o(gnt), .done_o(done), .res_o(res), .res_id_o(res_id), .err_o(err), .busy_o(busy),
    .mm_nd_o(mm_nd), .mm_invert_v_nd_o(mm_inv), .mm_normalize_o(mm_norm),
    .mm_t_mode_o(mm_tm), .mm_v_o(mm_v), .mm_u_i(mm_u), .mm_rdy_i(mm_rdy)
  );

  function automatic int exp_winner();
    for (int i = 0; i < N; i++) begin
      int c = (ptr_m + i) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete job: grant, issue pulse, held operands, done with result.
  task automatic run_job(input bit keep, output int waited);
    int w, lat;
    logic [1:0] op;
    logic [127:0] v, u;
    logic [N-1:0] expg;
    w = exp_winner();
    op = ops[w];
    v = vecs[w];
    expg = '0;
    expg[w] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt === '0 && waited < 100);
    tests++;
    if (gnt !== expg) begin
      fails++;
      $display("FAIL gnt: got %b want %b (waited %0d)", gnt, expg, waited);
      return;
    end
    if (!keep) req[w] = 1'b0;
    tests++;
    if (mm_v !== v || {mm_norm, mm_tm} !== {op == 2'b01, op == 2'b10} || {mm_nd, mm_inv} !== 2'b00) begin
      fails++;
      $display("FAIL issue_operands: v=%h nm=%b%b nd=%b%b want v=%h op=%b", mm_v, mm_norm, mm_tm,
               mm_nd, mm_inv, v, op);
    end
    @(negedge clk);
    tests++;
    if ({mm_nd, mm_inv} !== ((op == 2'b11) ? 2'b01 : 2'b10)) begin
      fails++;
      $display("FAIL start_pulse: nd,inv=%b%b want op=%b", mm_nd, mm_inv, op);
    end
    lat = $urandom_range(0, 4);
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) @(negedge clk);
      tests++;
      if (mm_v !== v || {mm_norm, mm_tm} !== {op == 2'b01, op == 2'b10} || gnt !== '0 ||
          done !== 1'b0 || (i > 0 && {mm_nd, mm_inv} !== 2'b00)) begin
        fails++;
        $display("FAIL hold: v=%h nm=%b%b gnt=%b done=%b nd=%b%b want v=%h op=%b", mm_v, mm_norm,
                 mm_tm, gnt, done, mm_nd, mm_inv, v, op);
      end
    end
    u = rand128();
    mm_u = u;
    mm_rdy = 1'b1;
    @(negedge clk);
    mm_rdy = 1'b0;
    mm_u = rand128();
    tests++;
    if (done !== 1'b1 || res !== u || res_id !== IDW'(w) || err !== 1'b0) begin
      fails++;
      $display("FAIL done: done=%b res=%h id=%0d err=%b want res=%h id=%0d", done, res, res_id,
               err, u, w);
    end
    ptr_m = (w + 1) % N;
    last_res = u;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || res !== u) begin
      fails++;
      $display("FAIL done_pulse: done=%b res=%h want 0 %h", done, res, u);
    end
  endtask

  task automatic test_reset();
    int waited;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({gnt, done, res, res_id, err, busy, mm_nd, mm_inv, mm_norm, mm_tm, mm_v} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: gnt=%b done=%b res=%h busy=%b v=%h", gnt, done, res, busy,
               mm_v);
    end
    rst = 1'b0;
    ptr_m = 0;
    for (int k = 1; k <= 4; k++) begin
      mm_rdy = (k == 2);
      mm_u = rand128();
      @(negedge clk);
      tests++;
      if (gnt !== '0 || done !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL drain: k=%0d gnt=%b done=%b busy=%b", k, gnt, done, busy);
      end
    end
    mm_rdy = 1'b0;
    ops[0] = 2'(0);
    vecs[0] = rand128();
    req = 3'b001;
    run_job(1'b0, waited);
    tests++;
    if (waited + 4 < DRAIN + 1 || waited + 4 > DRAIN + 2) begin
      fails++;
      $display("FAIL drain_latency: gnt at cycle %0d want %0d", waited + 4, DRAIN + 1);
    end
  endtask

  task automatic test_round_robin();
    int waited;
    for (int i = 0; i < N; i++) begin
      ops[i] = 2'b00;
      vecs[i] = rand128();
    end
    req = '1;
    repeat (6) run_job(1'b1, waited);
    req = '0;
  endtask

  task automatic test_ops();
    int waited;
    logic [1:0] seq[4];
    seq = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      ops[2] = seq[i];
      vecs[2] = rand128();
      req = 3'b100;
      run_job(1'b0, waited);
    end
  endtask

  task automatic test_random();
    int waited;
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) begin
        ops[i] = 2'($urandom_range(0, 3));
        vecs[i] = rand128();
      end
      req = 3'($urandom_range(1, 7));
      run_job(1'b0, waited);
    end
    req = '0;
  endtask

  task automatic test_spurious_rdy();
    req = '0;
    repeat (2) @(negedge clk);
    mm_u = rand128();
    mm_rdy = 1'b1;
    @(negedge clk);
    mm_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (done !== 1'b0 || res !== last_res || busy !== 1'b0) begin
        fails++;
        $display("FAIL spurious_rdy: done=%b res=%h busy=%b want res=%h", done, res, busy,
                 last_res);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_wait();
    int k;
    ops[1] = 2'b01;
    vecs[1] = rand128();
    req = 3'b010;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt === '0 && k < 100);
    tests++;
    if (gnt !== 3'b010) begin
      fails++;
      $display("FAIL rst_wait_gnt: got %b want 010", gnt);
    end
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    last_res = '0;
    mm_u = rand128();
    mm_rdy = 1'b1;
    @(negedge clk);
    mm_rdy = 1'b0;
    for (int c = 0; c < DRAIN + 6; c++) begin
      tests++;
      if (done !== 1'b0 || res !== '0 || gnt !== '0) begin
        fails++;
        $display("FAIL rst_wait: c=%0d done=%b res=%h gnt=%b want 0", c, done, res, gnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int k, c;
    ops[0] = 2'b00;
    vecs[0] = rand128();
    req = 3'b001;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt === '0 && k < 100);
    tests++;
    if (gnt !== 3'b001) begin
      fails++;
      $display("FAIL tmo_gnt: got %b want 001", gnt);
    end
    req = '0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (done !== 1'b1 && c < 60);
`ifdef MATMUL_ARB_TIMEOUT_EN
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || res !== last_res || c < TIMEOUT || c > TIMEOUT + 1) begin
      fails++;
      $display("FAIL timeout: done=%b err=%b at %0d res=%h want err at %0d res=%h", done, err, c,
               res, TIMEOUT, last_res);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_drain: done=%b err=%b busy=%b want 0 0 1", done, err, busy);
    end
`else
    tests++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL no_timeout: done=%b err=%b busy=%b want 0 0 1", done, err, busy);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ops[i] = '0;
      vecs[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_ops();
    test_random();
    test_spurious_rdy();
    test_reset_in_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
